// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam int unsigned PS2_DATA_BITS  = 8;
    localparam int unsigned PS2_FRAME_BITS = 11;

    // PS/2 uses odd parity over the eight data bits plus the parity bit.
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronizer for both PS/2 pins, level filter on the clock pin and
// a one-cycle strobe on each accepted falling edge of the filtered clock.
module ps2_sync_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic data_s
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);

    logic          clk_s1_q, clk_s2_q;
    logic          dat_s1_q, dat_s2_q;
    logic          clk_f_q, clk_f_d;
    logic [FW-1:0] cnt_q, cnt_d;
    logic          fall_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            clk_f_q  <= 1'b1;
            cnt_q    <= '0;
            fall_q   <= 1'b0;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
            clk_f_q  <= clk_f_d;
            cnt_q    <= cnt_d;
            fall_q   <= clk_f_q & ~clk_f_d;
        end
    end

    // The counter tracks how long the synchronized level has disagreed with clk_f.
    always_comb begin
        clk_f_d = clk_f_q;
        cnt_d   = '0;
        if (clk_s2_q != clk_f_q) begin
            if (cnt_q == FW'(FILTER_LEN - 1)) begin
                clk_f_d = clk_s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign fall   = fall_q;
    assign data_s = dat_s2_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: frames 11-bit packets, checks parity/stop,
// aborts stalled frames and keeps a four-byte history for the hex display.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [7:0]  scan_code,
    output logic        scan_valid,
    output logic        parity_err,
    output logic        frame_err,
    output logic [31:0] keyb_char
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic fall;
    logic data_s;

    ps2_state_t    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] timeout_q, timeout_d;
    logic [7:0]    scan_code_q, scan_code_d;
    logic [31:0]   keyb_char_q, keyb_char_d;
    logic          scan_valid_q, scan_valid_d;
    logic          parity_err_q, parity_err_d;
    logic          frame_err_q, frame_err_d;

    ps2_sync_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_sync (
        .clock   (clock),
        .reset   (reset),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .fall    (fall),
        .data_s  (data_s)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            parity_q     <= 1'b0;
            timeout_q    <= '0;
            scan_code_q  <= '0;
            keyb_char_q  <= '0;
            scan_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            parity_q     <= parity_d;
            timeout_q    <= timeout_d;
            scan_code_q  <= scan_code_d;
            keyb_char_q  <= keyb_char_d;
            scan_valid_q <= scan_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        parity_d     = parity_q;
        timeout_d    = '0;
        scan_code_d  = scan_code_q;
        keyb_char_d  = keyb_char_q;
        scan_valid_d = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;

        // A fall takes priority over the timeout terminal count.
        if (fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!data_s) begin
                        bit_cnt_d = '0;
                        state_d   = DATA;
                    end
                end
                DATA: begin
                    shreg_d = {data_s, shreg_q[7:1]};
                    if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) begin
                        state_d = PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                PARITY: begin
                    parity_d = data_s;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!data_s) begin
                        frame_err_d = 1'b1;
                    end else if (parity_ok(shreg_q, parity_q)) begin
                        scan_code_d  = shreg_q;
                        keyb_char_d  = {keyb_char_q[23:0], shreg_q};
                        scan_valid_d = 1'b1;
                    end else begin
                        parity_err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (timeout_q == TW'(TIMEOUT_CYCLES)) begin
                frame_err_d = 1'b1;
                state_d     = IDLE;
            end else begin
                timeout_d = timeout_q + 1'b1;
            end
        end
    end

    assign scan_code  = scan_code_q;
    assign scan_valid = scan_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign keyb_char  = keyb_char_q;

endmodule
